// File: rtl/div_seq.sv
// Sequential restoring shift-subtract divider: one quotient bit per clock,
// with a divide-by-zero shortcut and a start/done handshake on init.
module div_seq #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [WIDTH-1:0] DV,
   input  logic [WIDTH-1:0] DR,
   output logic [WIDTH-1:0] C,
   output logic [WIDTH-1:0] R,
   output logic             busy,
   output logic             done,
   output logic             err
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH:0]   a_r;
   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] d_r;
   logic [CW-1:0]    cnt_r;

   logic [WIDTH+1:0] shift_s;
   logic [WIDTH+1:0] diff_s;
   logic             ge_s;
   logic [WIDTH:0]   a_next_s;
   logic [WIDTH-1:0] q_next_s;

   // One restoring step; the borrow out of the extra top bit decides A >= D.
   always_comb begin
      shift_s  = {a_r, q_r[WIDTH-1]};
      diff_s   = shift_s - {2'b00, d_r};
      ge_s     = ~diff_s[WIDTH+1];
      q_next_s = {q_r[WIDTH-2:0], ge_s};
      if (ge_s) begin
         a_next_s = diff_s[WIDTH:0];
      end else begin
         a_next_s = shift_s[WIDTH:0];
      end
   end

   // Control FSM with datapath registers and registered result outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         a_r     <= {(WIDTH+1){1'b0}};
         q_r     <= {WIDTH{1'b0}};
         d_r     <= {WIDTH{1'b0}};
         cnt_r   <= {CW{1'b0}};
         C       <= {WIDTH{1'b0}};
         R       <= {WIDTH{1'b0}};
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (init) begin
                  if (DR != {WIDTH{1'b0}}) begin
                     a_r     <= {(WIDTH+1){1'b0}};
                     q_r     <= DV;
                     d_r     <= DR;
                     cnt_r   <= CW'(WIDTH);
                     busy    <= 1'b1;
                     state_r <= ITER;
                  end else begin
                     C       <= {WIDTH{1'b1}};
                     R       <= DV;
                     err     <= 1'b1;
                     done    <= 1'b1;
                     state_r <= DONE;
                  end
               end
            end
            ITER: begin
               a_r   <= a_next_s;
               q_r   <= q_next_s;
               cnt_r <= cnt_r - CW'(1);
               if (cnt_r == CW'(1)) begin
                  C       <= q_next_s;
                  R       <= a_next_s[WIDTH-1:0];
                  err     <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= DONE;
               end
            end
            DONE: begin
               // Result is held until init is released, so a held init cannot retrigger.
               if (!init) begin
                  done    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: cycle-level arithmetic model compared every
// cycle, plus directed vectors with hand-computed results and latencies.
module tb_div_seq;

   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         init = 1'b0;
   logic [W-1:0] DV = '0;
   logic [W-1:0] DR = '0;
   logic [W-1:0] C;
   logic [W-1:0] R;
   logic         busy;
   logic         done;
   logic         err;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   div_seq #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .init(init),
      .DV  (DV),
      .DR  (DR),
      .C   (C),
      .R   (R),
      .busy(busy),
      .done(done),
      .err (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: result from / and %, timing as a countdown of busy cycles.
   int m_c = 0, m_r = 0, m_err = 0, m_done = 0, m_iter = 0;
   int p_c = 0, p_r = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_c <= 0; m_r <= 0; m_err <= 0; m_done <= 0; m_iter <= 0;
      end else if (m_done != 0) begin
         if (!init) m_done <= 0;
      end else if (m_iter > 0) begin
         m_iter <= m_iter - 1;
         if (m_iter == 1) begin
            m_c <= p_c; m_r <= p_r; m_err <= 0; m_done <= 1;
         end
      end else if (init) begin
         if (DR == 0) begin
            m_c <= (1 << W) - 1; m_r <= int'(DV); m_err <= 1; m_done <= 1;
         end else begin
            p_c <= int'(DV) / int'(DR); p_r <= int'(DV) % int'(DR); m_iter <= W;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("C_model", int'(C), m_c);
         chk("R_model", int'(R), m_r);
         chk("err_model", int'(err), m_err);
         chk("done_model", int'(done), m_done);
         chk("busy_model", int'(busy), (m_iter > 0) ? 1 : 0);
         chk("busy_done_excl", int'(busy & done), 0);
      end
   end

   // Called at a negedge; starts an op, waits for done, checks, releases init.
   task automatic run_op(input int dv, input int dr, input int ec, input int er,
                         input int ee, input int elat);
      int n = 0;
      int nb = 0;
      DV = W'(dv); DR = W'(dr); init = 1'b1;
      forever begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (busy) nb++;
         if (done) break;
         if (n > 20) begin
            chk("timeout_done", n, elat);
            break;
         end
      end
      chk("latency", n, elat);
      chk("busy_cycles", nb, elat - 1);
      chk("C", int'(C), ec);
      chk("R", int'(R), er);
      chk("err", int'(err), ee);
      init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("done_release", int'(done), 0);
   endtask

   initial begin
      rst = 1'b1;
      @(posedge clk);
      chk_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rst_C", int'(C), 0);
      chk("rst_R", int'(R), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      rst = 1'b0;

      // Basic and divide-by-zero cases
      run_op(7, 2, 3, 1, 0, 4);
      run_op(5, 0, 7, 5, 1, 1);
      // Corner cases
      run_op(0, 3, 0, 0, 0, 4);
      run_op(7, 7, 1, 0, 0, 4);
      run_op(3, 5, 0, 3, 0, 4);
      run_op(7, 1, 7, 0, 0, 4);

      // Reset mid-iteration, with init held through reset
      DV = 3'd6; DR = 3'd4; init = 1'b1;
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("mid_busy", int'(busy), 1);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("midrst_C", int'(C), 0);
      chk("midrst_R", int'(R), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_busy", int'(busy), 0);
      rst = 1'b0;
      run_op(6, 4, 1, 2, 0, 4);

      // Operand changes and init toggling during ITER; hold init in DONE
      DV = 3'd7; DR = 3'd3; init = 1'b1;
      @(posedge clk);
      @(negedge clk);
      DV = 3'd1; DR = 3'd0; init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      init = 1'b1;
      @(posedge clk);
      @(negedge clk);
      init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      init = 1'b1;
      chk("chg_done", int'(done), 1);
      chk("chg_C", int'(C), 2);
      chk("chg_R", int'(R), 1);
      for (int k = 0; k < 4; k++) begin
         DV = 3'(k); DR = 3'(k + 1);
         @(posedge clk);
         @(negedge clk);
         chk("hold_done", int'(done), 1);
         chk("hold_busy", int'(busy), 0);
         chk("hold_C", int'(C), 2);
      end
      init = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("leave_done", int'(done), 0);
      chk("keep_C", int'(C), 2);
      chk("keep_R", int'(R), 1);

      // Exhaustive sweep
      for (int dv = 0; dv < 8; dv++) begin
         for (int dr = 0; dr < 8; dr++) begin
            if (dr == 0) begin
               run_op(dv, dr, 7, dv, 1, 1);
            end else begin
               run_op(dv, dr, dv / dr, dv % dr, 0, 4);
               chk("identity", int'(C) * dr + int'(R), dv);
               chk("r_lt_dr", (int'(R) < dr) ? 1 : 0, 1);
            end
         end
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 3, bit width of dividend, divisor, quotient and remainder.
REQ-002 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: init  input  1  start request, level-sensitive, sampled only in IDLE.
REQ-005 SHALL have port: DV  input  WIDTH  dividend, unsigned, sampled on the start edge.
REQ-006 SHALL have port: DR  input  WIDTH  divisor, unsigned, sampled on the start edge.
REQ-007 SHALL have port: C  output  WIDTH  quotient, registered.
REQ-008 SHALL have port: R  output  WIDTH  remainder, registered.
REQ-009 SHALL have port: busy  output  1  high while state is ITER.
REQ-010 SHALL have port: done  output  1  high while state is DONE.
REQ-011 SHALL have port: err  output  1  divide-by-zero flag for the current result.

Function
REQ-012 SHALL implement a restoring shift-subtract divider with states IDLE, ITER and DONE.
REQ-013 IDLE: on an edge with init=1 and DR!=0, SHALL load A=0, Q=DV, D=DR, cnt=WIDTH, and go to ITER.
REQ-014 IDLE: on an edge with init=1 and DR==0, SHALL go directly to DONE with C=all ones, R=DV, err=1.
REQ-015 ITER, each edge: SHALL shift {A,Q} left by one, then if shifted A>=D, set A=A-D and Q[0]=1, else Q[0]=0.
REQ-016 ITER, each edge: SHALL decrement cnt; the edge on which cnt goes 1->0 SHALL also load C=Q, R=A, set err=0, and enter DONE.
REQ-017 The internal partial remainder A SHALL be WIDTH+1 bits so the compare never overflows.
REQ-018 Latency SHALL be WIDTH+1 rising edges from the start edge to the first cycle with done=1; for WIDTH=3 this is 4 edges.
REQ-019 DONE SHALL hold C, R and err stable.
REQ-020 DONE SHALL return to IDLE on the first edge with init=0; while init stays 1 the block SHALL remain in DONE and SHALL NOT restart.
REQ-021 init changes during ITER SHALL be ignored.
REQ-022 DV and DR changes after the start edge SHALL NOT affect the result in progress.
REQ-023 C, R and err SHALL keep the previous result during IDLE and ITER; they update only on entry to DONE.
REQ-024 busy and done SHALL never be high together.
REQ-025 For DR!=0, results SHALL satisfy DV = C*DR + R with R < DR.

Reset
REQ-026 rst=1 on any edge SHALL force state IDLE and C=0, R=0, err=0, busy=0, done=0, A=0, Q=0, cnt=0.
REQ-027 rst SHALL take priority over init and over any state, including mid-ITER; no partial result SHALL reach C or R.
REQ-028 After rst deasserts with init=1, the next edge SHALL be treated as a start edge.

Verification
REQ-029 DV=7, DR=2, init pulse held high -> done=1 after exactly 4 edges; C=3, R=1, err=0; busy high for 3 cycles before that.
REQ-030 DV=5, DR=0, init=1 -> done=1 after 1 edge; C=7, R=5, err=1; busy never high.
REQ-031 Corner cases: DV=0,DR=3 -> C=0,R=0; DV=7,DR=7 -> C=1,R=0; DV=3,DR=5 -> C=0,R=3; DV=7,DR=1 -> C=7,R=0.
REQ-032 Start 6/4, then assert rst after 2 ITER edges -> C=0, R=0, done=0, busy=0, state IDLE; a following start with 6/4 gives C=1, R=2.
REQ-033 Change DV/DR and toggle init during ITER -> result matches the operands from the start edge; with init held high in DONE, done stays 1 and no restart occurs until init=0 for one edge.
REQ-034 Exhaustive check over all 64 DV/DR pairs, WIDTH=3, against REQ-025 and REQ-014.
